fetch_stage: RTL and testbench



---
 rtl/fetch_stage_pkg.sv | 14 +
 rtl/fetch_stage_if_id_register.sv | 31 +++
 rtl/fetch_stage.sv | 138 +++++++++++++
 tb/tb_fetch_stage.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_stage_pkg;

  localparam int unsigned INSTR_WIDTH     = 32;
  localparam int unsigned PC_STEP_DEFAULT = 4;
  localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if_id_register.sv
// IF/ID pipeline register: load a new instruction, hold it, or flush to a bubble.
module fetch_stage_if_id_register
  import fetch_stage_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic                   flush,
  input  logic [INSTR_WIDTH-1:0] instruction_d,
  input  logic [ADDR_WIDTH-1:0]  pc_plus4_d,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic [ADDR_WIDTH-1:0]  pc_plus4,
  output logic                   valid
);

  // Flush wins over load so a redirect never lets a wrong-path word through.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      instruction <= NOP_INSTR;
      pc_plus4    <= '0;
      valid       <= 1'b0;
    end else if (load) begin
      instruction <= instruction_d;
      pc_plus4    <= pc_plus4_d;
      valid       <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues single-outstanding fetches and feeds IF/ID.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned           PC_STEP    = PC_STEP_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imem_req,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic                   imem_ready,
  input  logic                   imem_rvalid,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   stall,
  input  logic                   branch_taken,
  input  logic [ADDR_WIDTH-1:0]  branch_target,
  output logic [INSTR_WIDTH-1:0] if_id_instruction,
  output logic [ADDR_WIDTH-1:0]  if_id_pc_plus4,
  output logic                   if_id_valid
);

  fetch_state_e           state, state_n;
  logic [ADDR_WIDTH-1:0]  pc, pc_n, pc_next;
  logic                   discard, discard_n;
  logic [INSTR_WIDTH-1:0] skid, skid_n;
  logic                   accept_c;
  logic                   load_c;
  logic                   flush_c;
  logic [INSTR_WIDTH-1:0] load_instr_c;

  assign imem_req  = (state == FETCH) && !reset;
  assign imem_addr = pc;
  assign accept_c  = imem_req && imem_ready;
  assign pc_next   = pc + ADDR_WIDTH'(PC_STEP);

  // Next-state decode; a branch overrides stall and every other event.
  always_comb begin
    state_n      = state;
    pc_n         = pc;
    discard_n    = discard;
    skid_n       = skid;
    load_c       = 1'b0;
    load_instr_c = imem_rdata;
    if (branch_taken) begin
      pc_n   = branch_target;
      skid_n = NOP_INSTR;
      case (state)
        FETCH: begin
          if (accept_c) begin
            state_n   = WAIT;
            discard_n = 1'b1;
          end else begin
            discard_n = discard && !imem_rvalid;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            state_n   = FETCH;
            discard_n = 1'b0;
          end else begin
            discard_n = 1'b1;
          end
        end
        default: state_n = FETCH;
      endcase
    end else begin
      case (state)
        FETCH: begin
          // A stale response left over from a reset may land here; it retires the discard.
          discard_n = discard && !imem_rvalid;
          if (accept_c) state_n = WAIT;
        end
        WAIT: begin
          if (imem_rvalid) begin
            if (discard) begin
              discard_n = 1'b0;
              state_n   = FETCH;
            end else if (!stall) begin
              load_c  = 1'b1;
              pc_n    = pc_next;
              state_n = FETCH;
            end else begin
              skid_n  = imem_rdata;
              state_n = HOLD;
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            load_c       = 1'b1;
            load_instr_c = skid;
            pc_n         = pc_next;
            state_n      = FETCH;
          end
        end
        default: state_n = FETCH;
      endcase
    end
  end

  // Without a stall, IF/ID takes a bubble unless a fresh word is loaded.
  assign flush_c = branch_taken || (!stall && !load_c);

  // An abandoned in-flight request must have its late response dropped after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      discard <= (discard || (state == WAIT)) && !imem_rvalid;
      skid    <= NOP_INSTR;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      discard <= discard_n;
      skid    <= skid_n;
    end
  end

  fetch_stage_if_id_register #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_if_id (
    .clk          (clk),
    .reset        (reset),
    .load         (load_c),
    .flush        (flush_c),
    .instruction_d(load_instr_c),
    .pc_plus4_d   (pc_next),
    .instruction  (if_id_instruction),
    .pc_plus4     (if_id_pc_plus4),
    .valid        (if_id_valid)
  );

  a_rvalid_only_when_expected : assert property (
    @(posedge clk) disable iff (reset) imem_rvalid |-> (state == WAIT || discard));

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage with a transaction-level reference model and directed anchors.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic [31:0] if_id_instruction;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;

  fetch_stage dut (
    .clk              (clk),
    .reset            (reset),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_ready       (imem_ready),
    .imem_rvalid      (imem_rvalid),
    .imem_rdata       (imem_rdata),
    .stall            (stall),
    .branch_taken     (branch_taken),
    .branch_target    (branch_target),
    .if_id_instruction(if_id_instruction),
    .if_id_pc_plus4   (if_id_pc_plus4),
    .if_id_valid      (if_id_valid)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Memory responder: single outstanding, latency mem_lat (0 = random 1..4).
  bit          mem_busy = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = 32'h0;
  int          mem_lat = 1;
  int          ready_pct = 100;

  // Reference model: fetch PC, outstanding request, skid word, IF/ID contents.
  logic [31:0] m_pc = 32'h0;
  bit          m_busy = 1'b0;
  bit          m_wanted = 1'b0;
  bit          m_skid_full = 1'b0;
  logic [31:0] m_skid = 32'h0;
  logic [31:0] m_instr = 32'h0;
  logic [31:0] m_pc4 = 32'h0;
  bit          m_valid = 1'b0;
  bit          model_armed = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'hE280_1001;
    return ((a * 32'h9E37_79B1) ^ 32'h1357_0000) | 32'h1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare against the model, advance model and memory.
  task automatic step(input bit rst, input bit st, input bit br, input logic [31:0] tgt);
    bit          m_req, m_acc, bus_acc, avail;
    logic [31:0] acc_addr, word;
    logic [31:0] n_pc, n_skid, n_instr, n_pc4;
    bit          n_busy, n_wanted, n_skid_full, n_valid;
    @(negedge clk);
    reset         = rst;
    stall         = st;
    branch_taken  = br;
    branch_target = br ? tgt : $urandom;
    imem_rvalid   = mem_busy && (mem_cnt == 0);
    imem_rdata    = imem_rvalid ? mem_word(mem_addr) : $urandom;
    imem_ready    = !mem_busy && ($urandom_range(99) < ready_pct);
    #1;
    m_req = !rst && !m_busy && !m_skid_full;
    if (model_armed) begin
      check("imem_req", 32'(imem_req), 32'(m_req));
      check("imem_addr", imem_addr, m_pc);
      check("if_id_instruction", if_id_instruction, m_instr);
      check("if_id_pc_plus4", if_id_pc_plus4, m_pc4);
      check("if_id_valid", 32'(if_id_valid), 32'(m_valid));
    end
    bus_acc  = imem_req && imem_ready;
    acc_addr = imem_addr;
    m_acc    = m_req && imem_ready;

    n_pc = m_pc; n_skid = m_skid; n_instr = m_instr; n_pc4 = m_pc4;
    n_busy = m_busy; n_wanted = m_wanted; n_skid_full = m_skid_full; n_valid = m_valid;
    if (rst) begin
      n_busy = 0; n_wanted = 0; n_skid_full = 0; n_pc = 32'h0;
      n_instr = 32'h0; n_pc4 = 32'h0; n_valid = 0;
    end else begin
      avail = 0;
      word  = 32'h0;
      if (imem_rvalid && m_busy && m_wanted) begin
        avail = 1; word = mem_word(m_pc);
      end else if (m_skid_full) begin
        avail = 1; word = m_skid;
      end
      if (imem_rvalid && m_busy) n_busy = 0;
      if (m_acc) begin
        n_busy = 1; n_wanted = !br;
      end else if (br && n_busy) begin
        n_wanted = 0;
      end
      if (br) begin
        n_pc = tgt; n_skid_full = 0; n_instr = 32'h0; n_pc4 = 32'h0; n_valid = 0;
      end else if (avail && !st) begin
        n_instr = word; n_pc4 = m_pc + 32'd4; n_valid = 1; n_pc = m_pc + 32'd4; n_skid_full = 0;
      end else if (avail) begin
        n_skid_full = 1; n_skid = word;
      end else if (!st) begin
        n_instr = 32'h0; n_pc4 = 32'h0; n_valid = 0;
      end
    end

    @(posedge clk);
    if (mem_busy && imem_rvalid) mem_busy = 0;
    else if (mem_busy) mem_cnt--;
    if (bus_acc) begin
      mem_busy = 1;
      mem_cnt  = (mem_lat > 0 ? mem_lat : int'($urandom_range(4, 1))) - 1;
      mem_addr = acc_addr;
    end
    m_pc = n_pc; m_skid = n_skid; m_instr = n_instr; m_pc4 = n_pc4;
    m_busy = n_busy; m_wanted = n_wanted; m_skid_full = n_skid_full; m_valid = n_valid;
    model_armed = 1'b1;
  endtask

  task automatic expect_ifid(input string tag, input logic [31:0] instr,
                             input logic [31:0] pc4, input bit vld);
    #1;
    check({tag, ".instr"}, if_id_instruction, instr);
    check({tag, ".pc4"}, if_id_pc_plus4, pc4);
    check({tag, ".valid"}, 32'(if_id_valid), 32'(vld));
  endtask

  task automatic expect_fetch(input string tag, input bit req, input logic [31:0] addr);
    #1;
    check({tag, ".req"}, 32'(imem_req), 32'(req));
    check({tag, ".addr"}, imem_addr, addr);
  endtask

  initial begin
    logic [31:0] tgt;
    // Reset release with 1-cycle memory.
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    expect_ifid("reset", 32'h0, 32'h0, 0);
    expect_fetch("reset", 0, 32'h0);
    step(0, 0, 0, 0);
    expect_ifid("first_accept", 32'h0, 32'h0, 0);
    step(0, 0, 0, 0);
    expect_ifid("first_instr", 32'hE280_1001, 32'h4, 1);
    expect_fetch("first_instr", 1, 32'h4);

    // 3-cycle memory: bubbles in between, no duplicate.
    mem_lat = 3;
    step(0, 0, 0, 0);
    expect_ifid("lat3_a", 32'h0, 32'h0, 0);
    step(0, 0, 0, 0);
    expect_ifid("lat3_b", 32'h0, 32'h0, 0);
    step(0, 0, 0, 0);
    expect_ifid("lat3_c", 32'h0, 32'h0, 0);
    step(0, 0, 0, 0);
    expect_ifid("lat3_d", mem_word(32'h4), 32'h8, 1);

    // Stall for 4 cycles while the response lands in the skid.
    mem_lat = 1;
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 0);
      expect_ifid("stall_hold", mem_word(32'h4), 32'h8, 1);
    end
    expect_fetch("stall_hold", 0, 32'h8);
    step(0, 0, 0, 0);
    expect_ifid("skid_out", mem_word(32'h8), 32'hC, 1);
    expect_fetch("skid_out", 1, 32'hC);

    // Branch while waiting; stale response two cycles later is dropped.
    mem_lat = 3;
    step(0, 0, 0, 0);
    step(0, 0, 1, 32'h100);
    expect_ifid("br_wait", 32'h0, 32'h0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    expect_ifid("stale_drop", 32'h0, 32'h0, 0);
    expect_fetch("stale_drop", 1, 32'h100);
    mem_lat = 1;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    expect_ifid("br_target", mem_word(32'h100), 32'h104, 1);

    // Branch and stall together: flush wins.
    step(0, 1, 1, 32'h200);
    expect_ifid("br_stall", 32'h0, 32'h0, 0);
    expect_fetch("br_stall", 0, 32'h200);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    expect_ifid("after_br_stall", mem_word(32'h200), 32'h204, 1);

    // PC wrap at the top of the address space.
    ready_pct = 0;
    step(0, 0, 1, 32'hFFFF_FFFC);
    ready_pct = 100;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    expect_ifid("wrap", mem_word(32'hFFFF_FFFC), 32'h0, 1);
    expect_fetch("wrap", 1, 32'h0);

    // Reset while waiting; the late response is ignored.
    mem_lat = 3;
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    expect_ifid("rst_wait", 32'h0, 32'h0, 0);
    expect_fetch("rst_wait", 0, 32'h0);
    step(1, 0, 0, 0);
    mem_lat = 1;
    step(0, 0, 0, 0);
    expect_ifid("late_rvalid", 32'h0, 32'h0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    expect_ifid("refetch", 32'hE280_1001, 32'h4, 1);

    // Randomized traffic against the reference model.
    mem_lat   = 0;
    ready_pct = 70;
    for (int i = 0; i < 4000; i++) begin
      tgt = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(9) == 0) tgt = 32'hFFFF_FFFC - 32'(4 * $urandom_range(2));
      step($urandom_range(99) < 1, $urandom_range(99) < 30, $urandom_range(99) < 6, tgt);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
